// File: rtl/core_pkg.sv
// Shared encodings for the 16-bit core: ALU opcodes, branch conditions and FLAG bit positions.
// flag_mask_f says which FLAG bits each ALU opcode is allowed to overwrite.
package core_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int RW_DEFAULT = 4;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    ALU_ADD     = 3'b000,
    ALU_SUB     = 3'b001,
    ALU_XOR     = 3'b010,
    ALU_RED     = 3'b011,
    ALU_SLL     = 3'b100,
    ALU_SRA     = 3'b101,
    ALU_ROR     = 3'b110,
    ALU_PADDSUB = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NE     = 3'b000,
    BR_EQ     = 3'b001,
    BR_GT     = 3'b010,
    BR_LT     = 3'b011,
    BR_GE     = 3'b100,
    BR_LE     = 3'b101,
    BR_OVFL   = 3'b110,
    BR_UNCOND = 3'b111
  } br_cond_e;

  // Arithmetic ops own all three flags, logic/shift ops only Z, reductions none.
  function automatic logic [2:0] flag_mask_f(input alu_op_e op);
    logic [2:0] mask;
    mask = 3'b000;
    case (op)
      ALU_ADD, ALU_SUB:                   mask = 3'b111;
      ALU_XOR, ALU_SLL, ALU_SRA, ALU_ROR: mask = 3'b100;
      ALU_RED, ALU_PADDSUB:               mask = 3'b000;
      default:                            mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ex_mem_flag_stage_br_cond_eval.sv
// Pure combinational branch resolver: maps a {Z,V,N} flag vector and a condition code
// to a taken decision, gated by the branch-valid qualifier.
module br_cond_eval
  import core_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  input  logic       valid,
  output logic       taken
);

  logic z;
  logic v;
  logic n;
  logic cond_true;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    cond_true = 1'b0;
    case (br_cond_e'(cond))
      BR_NE:     cond_true = ~z;
      BR_EQ:     cond_true = z;
      BR_GT:     cond_true = ~z & ~n;
      BR_LT:     cond_true = n;
      BR_GE:     cond_true = z | ~n;
      BR_LE:     cond_true = n | z;
      BR_OVFL:   cond_true = v;
      BR_UNCOND: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
  end

  assign taken = valid & cond_true;

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX->MEM pipeline register plus the architectural FLAG register. Branches in ID are resolved
// against the flag value being written this cycle, so a flag-setting op never stalls a branch.
module ex_mem_flag_stage
  import core_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [2:0]    ex_alu_op,
  input  logic          ex_flag_en,
  input  logic [DW-1:0] ex_alu_out,
  input  logic [2:0]    ex_alu_flags,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          ex_memwrite,
  input  logic [DW-1:0] ex_st_data,
  input  logic          id_br_valid,
  input  logic [2:0]    id_br_cond,
  output logic          br_taken,
  output logic [2:0]    flags_q,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_out,
  output logic [RW-1:0] mem_rd,
  output logic          mem_regwrite,
  output logic          mem_memread,
  output logic          mem_memwrite,
  output logic [DW-1:0] mem_st_data
);

  logic       flag_upd;
  logic [2:0] flag_mask;
  logic [2:0] flags_next;

  // A reset cycle discards the EX instruction, so it must not leak into the forwarded flags either.
  always_comb begin
    flag_upd   = ex_valid & ex_flag_en & ~stall & ~flush & ~rst;
    flag_mask  = flag_mask_f(alu_op_e'(ex_alu_op));
    flags_next = flags_q;
    if (flag_upd) begin
      flags_next = (flag_mask & ex_alu_flags) | (~flag_mask & flags_q);
    end
  end

  br_cond_eval u_br_cond_eval (
    .flags (flags_next),
    .cond  (id_br_cond),
    .valid (id_br_valid),
    .taken (br_taken)
  );

  // Flush wins over stall; flushed data fields simply keep their old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q      <= 3'b000;
      mem_valid    <= 1'b0;
      mem_alu_out  <= '0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_st_data  <= '0;
    end else if (flush) begin
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
    end else if (!stall) begin
      flags_q      <= flags_next;
      mem_valid    <= ex_valid;
      mem_alu_out  <= ex_alu_out;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite & ex_valid;
      mem_memread  <= ex_memread & ex_valid;
      mem_memwrite <= ex_memwrite & ex_valid;
      mem_st_data  <= ex_st_data;
    end
  end

endmodule
